// File: rtl/topk_insert_sorter.sv
// topk_insert_sorter
//   DEPTH-entry systolic insertion sorter. It keeps the best DEPTH {tag,key}
//   records of a frame in sorted order, with slot0 holding the best record. It
//   accepts one insert per cycle while filling. After a flush it streams the
//   records out best-first over a valid/ready handshake.
//
// Ports
//   clk        in   1        clock, rising edge
//   reset      in   1        synchronous, active-high
//   clear      in   1        synchronous empty of the array, return to FILL
//   in_valid   in   1        input record valid
//   in_ready   out  1        record accepted (FILL only)
//   in_key     in   KEY_W    record key (compared, unsigned)
//   in_tag     in   TAG_W    record tag (carried, never compared)
//   flush      in   1        end of frame, start the drain
//   out_valid  out  1        output record valid (DRAIN only)
//   out_ready  in   1        downstream accepts the output record
//   out_key    out  KEY_W    slot0 key
//   out_tag    out  TAG_W    slot0 tag
//   out_last   out  1        final record of the frame
//   count      out  clog2(DEPTH+1)  occupied slots
//   dropped    out  CNT_W    records rejected this frame, saturating
module topk_insert_sorter #(
  parameter int KEY_W   = 32,
  parameter int TAG_W   = 3,
  parameter int DEPTH   = 8,
  parameter int DESCEND = 0,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [KEY_W-1:0]           in_key,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [KEY_W-1:0]           out_key,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           dropped
);

  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t               r_state, w_state_nxt;
  logic [KEY_W-1:0]     r_key [DEPTH];
  logic [TAG_W-1:0]     r_tag [DEPTH];
  logic [DEPTH-1:0]     r_vld;
  logic [CW-1:0]        r_count;
  logic [CNT_W-1:0]     r_dropped;

  logic [KEY_W-1:0]     w_key_nxt [DEPTH];
  logic [TAG_W-1:0]     w_tag_nxt [DEPTH];
  logic [DEPTH-1:0]     w_vld_nxt;
  logic [DEPTH-1:0]     w_take;
  logic                 w_full;
  logic                 w_ins;
  logic                 w_out_hs;
  logic                 w_last_hs;

  // Strict compare, so a new record never overtakes an equal one.
  function automatic logic f_better(input logic [KEY_W-1:0] a,
                                    input logic [KEY_W-1:0] b);
    return (DESCEND != 0) ? (a > b) : (a < b);
  endfunction

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_ins     = (r_state == S_FILL) && in_valid;
  assign w_out_hs  = (r_state == S_DRAIN) && out_ready;
  assign w_last_hs = w_out_hs && (r_count == CW'(1));

  // The array is sorted and its valid slots are contiguous from slot0. So
  // w_take is 0...0 followed by 1...1. The first set bit is the insertion
  // point, and every later set bit takes its upper neighbour.
  always_comb begin
    w_take = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_take[i] = !r_vld[i] || f_better(in_key, r_key[i]);
    end
  end

  always_comb begin
    w_key_nxt = r_key;
    w_tag_nxt = r_tag;
    w_vld_nxt = r_vld;
    if (w_ins) begin
      if (w_take[0]) begin
        w_key_nxt[0] = in_key;
        w_tag_nxt[0] = in_tag;
        w_vld_nxt[0] = 1'b1;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (w_take[i]) begin
          if (!w_take[i-1]) begin
            w_key_nxt[i] = in_key;
            w_tag_nxt[i] = in_tag;
            w_vld_nxt[i] = 1'b1;
          end else begin
            w_key_nxt[i] = r_key[i-1];
            w_tag_nxt[i] = r_tag[i-1];
            w_vld_nxt[i] = r_vld[i-1];
          end
        end
      end
    end else if (w_out_hs) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        w_key_nxt[i] = r_key[i+1];
        w_tag_nxt[i] = r_tag[i+1];
        w_vld_nxt[i] = r_vld[i+1];
      end
      w_key_nxt[DEPTH-1] = '0;
      w_tag_nxt[DEPTH-1] = '0;
      w_vld_nxt[DEPTH-1] = 1'b0;
    end
  end

  // A flush whose insert lands in the same cycle still counts as a
  // non-empty frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (flush && ((r_count != '0) || w_ins)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_hs) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state   <= S_FILL;
      r_vld     <= '0;
      r_count   <= '0;
      r_dropped <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_key[i] <= '0;
        r_tag[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_vld   <= w_vld_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_key[i] <= w_key_nxt[i];
        r_tag[i] <= w_tag_nxt[i];
      end
      if (w_ins && !w_full) begin
        r_count <= r_count + CW'(1);
      end else if (w_out_hs) begin
        r_count <= r_count - CW'(1);
      end
      // When the array is full, an insert either is rejected or pushes
      // the last slot out. Either way one record is lost.
      if (w_last_hs) begin
        r_dropped <= '0;
      end else if (w_ins && w_full && (r_dropped != '1)) begin
        r_dropped <= r_dropped + CNT_W'(1);
      end
    end
  end

  assign in_ready  = (r_state == S_FILL);
  assign out_valid = (r_state == S_DRAIN);
  assign out_key   = r_key[0];
  assign out_tag   = r_tag[0];
  assign out_last  = out_valid && (r_count == CW'(1));
  assign count     = r_count;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_topk_insert_sorter.sv
module tb_topk_insert_sorter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: ascending, DEPTH=4, 32-bit keys
  logic        a_clear = 0, a_in_valid = 0, a_flush = 0, a_out_ready = 0;
  logic        a_in_ready, a_out_valid, a_out_last;
  logic [31:0] a_in_key = '0, a_out_key;
  logic [2:0]  a_in_tag = '0, a_out_tag;
  logic [2:0]  a_count;
  logic [15:0] a_dropped;

  // Instance D: descending, DEPTH=4, 8-bit keys, 2-bit saturating drop count
  logic        d_clear = 0, d_in_valid = 0, d_flush = 0, d_out_ready = 0;
  logic        d_in_ready, d_out_valid, d_out_last;
  logic [7:0]  d_in_key = '0, d_out_key;
  logic [2:0]  d_in_tag = '0, d_out_tag;
  logic [2:0]  d_count;
  logic [1:0]  d_dropped;

  topk_insert_sorter #(.KEY_W(32), .TAG_W(3), .DEPTH(4), .DESCEND(0), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .clear(a_clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_key(a_in_key), .in_tag(a_in_tag),
    .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_key(a_out_key), .out_tag(a_out_tag), .out_last(a_out_last),
    .count(a_count), .dropped(a_dropped));

  topk_insert_sorter #(.KEY_W(8), .TAG_W(3), .DEPTH(4), .DESCEND(1), .CNT_W(2)) u_d (
    .clk(clk), .reset(reset), .clear(d_clear),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_key(d_in_key), .in_tag(d_in_tag),
    .flush(d_flush), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_key(d_out_key), .out_tag(d_out_tag), .out_last(d_out_last),
    .count(d_count), .dropped(d_dropped));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ins_a(input logic [31:0] k, input logic [2:0] t);
    a_in_valid = 1'b1; a_in_key = k; a_in_tag = t;
    tick;
    a_in_valid = 1'b0;
  endtask

  task automatic ins_d(input logic [7:0] k);
    d_in_valid = 1'b1; d_in_key = k; d_in_tag = 3'd0;
    tick;
    d_in_valid = 1'b0;
  endtask

  task automatic flush_a;
    a_flush = 1'b1;
    tick;
    a_flush = 1'b0;
  endtask

  // Drains n records from A and checks keys, out_last and count along the way.
  task automatic drain_a(input string nm, input int n,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    a_out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({nm, "_valid"}, a_out_valid, 1'b1);
      chk({nm, "_key"},   a_out_key, e[i]);
      chk({nm, "_last"},  a_out_last, (i == n - 1));
      chk({nm, "_count"}, a_count, n - i);
      tick;
    end
    a_out_ready = 1'b0;
    chk({nm, "_done_valid"},   a_out_valid, 1'b0);
    chk({nm, "_done_ready"},   a_in_ready, 1'b1);
    chk({nm, "_done_count"},   a_count, 0);
    chk({nm, "_done_dropped"}, a_dropped, 0);
  endtask

  initial begin
    logic [2:0] etag [3];

    // Reset state
    tick; tick;
    reset = 1'b0;
    chk("rst_a_in_ready",  a_in_ready, 1'b1);
    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_out_last",  a_out_last, 1'b0);
    chk("rst_a_count",     a_count, 0);
    chk("rst_a_dropped",   a_dropped, 0);
    chk("rst_d_count",     d_count, 0);

    // T1: ascending sort and drain
    ins_a(9, 0); chk("t1_visible", a_out_key, 9);
    ins_a(3, 0); ins_a(7, 0); ins_a(1, 0);
    chk("t1_count_full", a_count, 4);
    chk("t1_dropped", a_dropped, 0);
    flush_a;
    drain_a("t1", 4, 1, 3, 7, 9);

    // T2: full array, insert displaces the tail, too-large key rejected
    ins_a(9, 0); ins_a(3, 0); ins_a(7, 0); ins_a(1, 0);
    ins_a(5, 0);
    chk("t2_drop_displace", a_dropped, 1);
    chk("t2_count", a_count, 4);
    ins_a(12, 0);
    chk("t2_drop_reject", a_dropped, 2);
    flush_a;
    chk("t2_dropped_in_drain", a_dropped, 2);
    drain_a("t2", 4, 1, 3, 5, 7);

    // T3: equal keys keep arrival order
    ins_a(5, 1); ins_a(5, 2); ins_a(5, 3);
    flush_a;
    etag[0] = 3'd1; etag[1] = 3'd2; etag[2] = 3'd3;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t3_tag", a_out_tag, etag[i]);
      chk("t3_last", a_out_last, (i == 2));
      tick;
    end
    a_out_ready = 1'b0;
    chk("t3_done_valid", a_out_valid, 1'b0);

    // T4: descending keeps the largest, drop counter saturates at 3
    ins_d(2); ins_d(8); ins_d(4); ins_d(6); ins_d(10);
    chk("t4_dropped", d_dropped, 1);
    chk("t4_count", d_count, 4);
    ins_d(1); ins_d(1);
    chk("t4_dropped_3", d_dropped, 3);
    ins_d(1);
    chk("t4_dropped_sat", d_dropped, 3);
    d_flush = 1'b1; tick; d_flush = 1'b0;
    d_out_ready = 1'b1;
    chk("t4_k0", d_out_key, 10); tick;
    chk("t4_k1", d_out_key, 8);  tick;
    chk("t4_k2", d_out_key, 6);  tick;
    chk("t4_k3", d_out_key, 4);
    chk("t4_last", d_out_last, 1'b1);
    tick;
    d_out_ready = 1'b0;
    chk("t4_done_valid", d_out_valid, 1'b0);
    chk("t4_done_dropped", d_dropped, 0);

    // T5: backpressure holds output and blocks input
    ins_a(4, 0); ins_a(2, 0); ins_a(6, 0);
    flush_a;
    chk("t5_first", a_out_key, 2);
    a_out_ready = 1'b1; tick; a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_key = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t5_hold_key", a_out_key, 4);
      chk("t5_hold_valid", a_out_valid, 1'b1);
      chk("t5_hold_last", a_out_last, 1'b0);
      chk("t5_in_ready", a_in_ready, 1'b0);
      chk("t5_hold_count", a_count, 2);
    end
    a_in_valid = 1'b0;
    drain_a("t5", 2, 4, 6, 0, 0);
    // flush on an empty array is ignored
    flush_a;
    chk("t5_empty_flush_valid", a_out_valid, 1'b0);
    chk("t5_empty_flush_ready", a_in_ready, 1'b1);
    tick;
    chk("t5_empty_flush_valid2", a_out_valid, 1'b0);

    // T6a: clear mid-drain
    ins_a(8, 0); ins_a(6, 0); ins_a(2, 0); ins_a(4, 0);
    flush_a;
    a_out_ready = 1'b1; tick; tick; a_out_ready = 1'b0;
    chk("t6_mid_key", a_out_key, 6);
    a_clear = 1'b1; tick; a_clear = 1'b0;
    chk("t6c_valid", a_out_valid, 1'b0);
    chk("t6c_count", a_count, 0);
    chk("t6c_ready", a_in_ready, 1'b1);
    ins_a(4, 0); ins_a(2, 0);
    flush_a;
    drain_a("t6c", 2, 2, 4, 0, 0);

    // T6b: reset mid-drain
    ins_a(8, 0); ins_a(6, 0); ins_a(2, 0); ins_a(4, 0);
    flush_a;
    a_out_ready = 1'b1; tick; tick; a_out_ready = 1'b0;
    reset = 1'b1; tick; reset = 1'b0;
    chk("t6r_valid", a_out_valid, 1'b0);
    chk("t6r_count", a_count, 0);
    chk("t6r_ready", a_in_ready, 1'b1);
    ins_a(4, 0); ins_a(2, 0);
    flush_a;
    drain_a("t6r", 2, 2, 4, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
